neuron_alu_pipe: RTL
====================

// Module: neuron_alu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the neuron datapath's combinational ALU.
//  - Two register stages with valid/ready flow control.
//  - Width-generic; extended op set (saturating add/sub, signed min/max).
//  - Carries a tag field alongside each operation, so the neuron controller can
//    track membrane-potential/weight updates in flight.
//  - Sits between the neuron controller (issue side) and the membrane register file (writeback side).
// PARAMETERS
//  WIDTH   32  operand/result width in bits; legal range 8..64
//  TAG_W    4  width of the sideband tag passed through unchanged
//  SHAMT_W  $clog2(WIDTH)  shift-amount bits taken from b[SHAMT_W-1:0]; derived, do not override
// PORTS
//  clk        in   1        clock; all state updates on rising edge
//  rst        in   1        reset; synchronous, active-high
//  in_valid   in   1        operation offered on aluop/a/b/in_tag
//  in_ready   out  1        pipe accepts the operation this cycle
//  aluop      in   4        neuron_alu_pkg::aluop_t
//  a, b       in   WIDTH    operands
//  in_tag     in   TAG_W    sideband tag
//  out_valid  out  1        f/out_tag/sat_flag hold a valid result
//  out_ready  in   1        consumer takes the result this cycle
//  f          out  WIDTH    result
//  out_tag    out  TAG_W    tag of the result
//  sat_flag   out  1        result was clamped (saturating ops only)
// BEHAVIOUR
//  - Reset: s1_valid=0, s2_valid=0, out_valid=0, f=0, out_tag=0, sat_flag=0.
//    in_ready=1 in the first cycle after reset deasserts.
//  - Handshakes:
//    - Accept occurs when in_valid & in_ready.
//    - Output transfer occurs when out_valid & out_ready.
//    - Offered data may change only after it is accepted or transferred.
//  - Stage 1 (S1) registers op, a, b and tag.
//  - Stage 2 (S2) registers result, tag and sat_flag; it is computed combinationally from S1.
//  - Latency: accepted in cycle N -> out_valid in cycle N+2 when there is no stall.
//    Throughput: 1 op/cycle.
//  - Stall rules:
//    - s2_adv = !s2_valid | out_ready.
//    - s1_adv = !s1_valid | s2_adv.
//    - in_ready = s1_adv.
//    - A stalled stage holds all of its fields.
//    - No bubble collapse is needed beyond these rules. A full pipe with out_ready=1
//      accepts a new op every cycle.
//  - Simultaneous accept and output transfer in one cycle is legal. The counts
//    stay consistent and no op is dropped or duplicated.
//  - Ops (arithmetic is modulo 2^WIDTH unless noted):
//    - ADD=0: a+b
//    - SLL=1: a<<sh
//    - SRA=2: $signed(a)>>>sh
//    - SUB=3: a-b
//    - XOR=4: a^b
//    - SRL=5: a>>sh
//    - OR=6: a|b
//    - AND=7: a&b
//    - SADD=8, SSUB=9: signed saturating; clamp to +2^(W-1)-1 or -2^(W-1) and set sat_flag
//    - MIN=10, MAX=11: signed
//    - PASSB=12: b
//    - 13..15 reserved: result 0, sat_flag 0, the op still flows and the tag is returned
//  - sat_flag is 0 for every op except a clamping SADD or SSUB.
//  - rst asserted mid-operation: all in-flight ops are discarded and the next cycle
//    shows the reset values. Ops are not replayed.
// CONFIGURATION
//  Macro NEURON_ALU_SAT_EN:
//  - Defined: SADD/SSUB saturate as specified above.
//  - Undefined:
//    - SADD and SSUB compute the wrapping ADD and SUB results.
//    - sat_flag is tied to 0.
//    - The saturation logic is absent from the netlist.
//    - Port list and latency are unchanged.
// STRUCTURE
//  - neuron_alu_pkg holds:
//    - aluop_t, a 4-bit enum: ALU_ADD..ALU_PASSB.
//    - The constant NEURON_ALU_LATENCY = 2.
//  - Sub-module neuron_alu_core: the purely combinational op decode and datapath,
//    carrying parameter WIDTH, driving result and sat. It sits between S1 and S2.
//  - The top level holds only the pipeline registers and the handshake logic.
// TESTING (WIDTH=32 unless noted)
//  1. Reset, then ADD a=5 b=7 tag=3 with out_ready=1 -> two cycles later:
//     out_valid=1, f=12, out_tag=3, sat_flag=0.
//  2. SADD a=32'h7FFF_FFF0 b=32'h20:
//     - With the macro: f=32'h7FFF_FFFF, sat_flag=1.
//     - Without the macro: f=32'h8000_0010, sat_flag=0.
//  3. SRA a=32'h8000_0000 b=31 -> f=32'hFFFF_FFFF.
//     SRL with the same operands -> f=1.
//     WIDTH=16: SLL a=1 b=16'h0013 -> uses sh=3 -> f=8.
//  4. Back-to-back stream of 8 ops while out_ready toggles 1,0,0,1,... ->
//     - All 8 results arrive in order with matching tags.
//     - in_ready=0 whenever both stages are full and out_ready=0.
//  5. Assert rst for 1 cycle while 2 ops are in flight -> out_valid=0 and f=0 the
//     next cycle, and neither op ever appears.
//  6. MIN a=-3 b=2 -> f=32'hFFFF_FFFD.
//     MAX with the same operands -> f=2.
//     Op 14 -> f=0, and its tag is returned.

Source files
------------

// File: rtl/neuron_alu_pkg.sv
// Package for the pipelined neuron ALU.
// Holds the operation encoding shared by the issue side (neuron controller)
// and the datapath, plus the fixed pipeline latency.
// Optional feature macro used by this block: NEURON_ALU_SAT_EN
package neuron_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SLL   = 4'd1,
        ALU_SRA   = 4'd2,
        ALU_SUB   = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SRL   = 4'd5,
        ALU_OR    = 4'd6,
        ALU_AND   = 4'd7,
        ALU_SADD  = 4'd8,
        ALU_SSUB  = 4'd9,
        ALU_MIN   = 4'd10,
        ALU_MAX   = 4'd11,
        ALU_PASSB = 4'd12
    } aluop_t;

    // Cycles from accept to out_valid when the pipe is not stalled.
    localparam int NEURON_ALU_LATENCY = 2;

endpackage

// File: rtl/neuron_alu_core.sv
// Combinational op decode and datapath of the neuron ALU.
// Sits between the S1 operand registers and the S2 result registers.
// Ports:
//   op      in   4       operation code (neuron_alu_pkg::aluop_t encoding)
//   a, b    in   WIDTH   operands; shift amount is b[SHAMT_W-1:0]
//   result  out  WIDTH   operation result
//   sat     out  1       result was clamped by SADD/SSUB
// Macro NEURON_ALU_SAT_EN: when defined SADD/SSUB saturate; otherwise they
// wrap like ADD/SUB, sat is constant 0 and no clamp logic is built.
module neuron_alu_core
    import neuron_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             sat
);

    aluop_t             op_e;
    logic [SHAMT_W-1:0] sh;

    assign op_e = aluop_t'(op);
    assign sh   = b[SHAMT_W-1:0];

`ifdef NEURON_ALU_SAT_EN
    // Signed add or subtract with clamping. Subtraction is x + ~y + 1, so the
    // usual "operands share a sign, sum does not" overflow test still holds
    // on the effective addend. Returns {overflow, clamped_sum}.
    function automatic logic [WIDTH:0] sat_addsub(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             sub
    );
        logic [WIDTH-1:0] y_eff;
        logic [WIDTH-1:0] sum;
        logic             ovf;
        y_eff = sub ? ~y : y;
        sum   = x + y_eff + {{(WIDTH-1){1'b0}}, sub};
        ovf   = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        if (ovf) begin
            // Overflow direction follows the sign of x.
            sum = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return {ovf, sum};
    endfunction
`endif

    always_comb begin
        result = '0;
        sat    = 1'b0;
        case (op_e)
            ALU_ADD:   result = a + b;
            ALU_SLL:   result = a << sh;
            ALU_SRA:   result = $unsigned($signed(a) >>> sh);
            ALU_SUB:   result = a - b;
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> sh;
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
`ifdef NEURON_ALU_SAT_EN
            ALU_SADD:  {sat, result} = sat_addsub(a, b, 1'b0);
            ALU_SSUB:  {sat, result} = sat_addsub(a, b, 1'b1);
`else
            ALU_SADD:  result = a + b;
            ALU_SSUB:  result = a - b;
`endif
            ALU_MIN:   result = ($signed(a) < $signed(b)) ? a : b;
            ALU_MAX:   result = ($signed(a) > $signed(b)) ? a : b;
            ALU_PASSB: result = b;
            // Reserved codes still flow through the pipe with a zero result.
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/neuron_alu_pipe.sv
// Two-stage pipelined neuron ALU with valid/ready flow control.
// S1 registers op/a/b/tag, S2 registers result/tag/sat_flag produced by
// neuron_alu_core from S1. Latency 2, throughput 1 op/cycle.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   issue handshake for aluop, a, b, in_tag
//   aluop  [3:0]        neuron_alu_pkg::aluop_t
//   a, b   [WIDTH-1:0]  operands
//   in_tag [TAG_W-1:0]  sideband tag, returned unchanged on out_tag
//   out_valid/out_ready result handshake for f, out_tag, sat_flag
//   sat_flag            SADD/SSUB result was clamped
// Macro NEURON_ALU_SAT_EN: enables saturation in the core (see core header).
module neuron_alu_pipe
    import neuron_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic [TAG_W-1:0] out_tag,
    output logic             sat_flag
);

    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_op_q,    s1_op_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_f_q,     s2_f_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
    logic             s2_sat_q,   s2_sat_d;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] core_result;
    logic             core_sat;

    // A stage may take new contents when it is empty or its contents leave.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    neuron_alu_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .op     (s1_op_q),
        .a      (s1_a_q),
        .b      (s1_b_q),
        .result (core_result),
        .sat    (core_sat)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_f_d     = s2_f_q;
        s2_tag_d   = s2_tag_q;
        s2_sat_d   = s2_sat_q;

        // ---- issue -> S1
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d  = aluop;
                s1_a_d   = a;
                s1_b_d   = b;
                s1_tag_d = in_tag;
            end
        end

        // ---- S1 -> S2 (through the combinational core)
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_f_d   = core_result;
                s2_tag_d = s1_tag_q;
                s2_sat_d = core_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_f_q     <= '0;
            s2_tag_q   <= '0;
            s2_sat_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_f_q     <= s2_f_d;
            s2_tag_q   <= s2_tag_d;
            s2_sat_q   <= s2_sat_d;
        end
    end

    // S1 operands are only meaningful under s1_valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        s1_op_q  <= s1_op_d;
        s1_a_q   <= s1_a_d;
        s1_b_q   <= s1_b_d;
        s1_tag_q <= s1_tag_d;
    end

    // ---- S2 -> output
    assign out_valid = s2_valid_q;
    assign f         = s2_f_q;
    assign out_tag   = s2_tag_q;
    assign sat_flag  = s2_sat_q;

endmodule
